// File: rtl/keccak800_pkg.sv
// Shared constants, lane helpers and the theta step for the Keccak-f[800] permutation engine.
package keccak800_pkg;

    localparam int LANE_W    = 32;
    localparam int STATE_W   = 800;
    localparam int RC_COUNT  = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [LANE_W-1:0] RC [0:RC_COUNT-1] = '{
        32'h00000001, 32'h00008082, 32'h0000808A, 32'h80008000, 32'h0000808B,
        32'h80000001, 32'h80008081, 32'h00008009, 32'h0000008A, 32'h00000088,
        32'h80008009, 32'h8000000A, 32'h8000808B, 32'h0000008B, 32'h00008089,
        32'h00008003, 32'h00008002, 32'h00000080, 32'h0000800A, 32'h8000000A,
        32'h80008081, 32'h00008080
    };

    // Rotation offsets indexed by idx(x,y), already reduced mod 32.
    localparam logic [4:0] RHO [0:24] = '{
        5'd0,  5'd1,  5'd30, 5'd28, 5'd27,
        5'd4,  5'd12, 5'd6,  5'd23, 5'd20,
        5'd3,  5'd10, 5'd11, 5'd25, 5'd7,
        5'd9,  5'd13, 5'd15, 5'd21, 5'd8,
        5'd18, 5'd2,  5'd29, 5'd24, 5'd14
    };

    function automatic int idx(input int x, input int y);
        return x + 5 * y;
    endfunction

    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input logic [4:0] n);
        return (v << n) | (v >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [LANE_W-1:0] rc_at(input logic [4:0] i);
        if (i < 5'd22) begin
            return RC[i];
        end else begin
            return '0;
        end
    endfunction

    function automatic logic [STATE_W-1:0] theta(input logic [STATE_W-1:0] a);
        logic [LANE_W-1:0] c [0:4];
        logic [LANE_W-1:0] d;
        logic [STATE_W-1:0] res;
        for (int x = 0; x < 5; x++) begin
            c[x] = a[LANE_W*idx(x, 0) +: LANE_W] ^ a[LANE_W*idx(x, 1) +: LANE_W] ^
                   a[LANE_W*idx(x, 2) +: LANE_W] ^ a[LANE_W*idx(x, 3) +: LANE_W] ^
                   a[LANE_W*idx(x, 4) +: LANE_W];
        end
        res = a;
        for (int x = 0; x < 5; x++) begin
            d = c[(x + 4) % 5] ^ rotl(c[(x + 1) % 5], 5'd1);
            for (int y = 0; y < 5; y++) begin
                res[LANE_W*idx(x, y) +: LANE_W] = a[LANE_W*idx(x, y) +: LANE_W] ^ d;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/keccak800_round.sv
// One combinational Keccak-f[800] round: theta, rho-pi, chi, then iota with the supplied constant.
module keccak800_round
    import keccak800_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    input  logic [LANE_W-1:0]  rc,
    output logic [STATE_W-1:0] state_out
);

    logic [STATE_W-1:0] theta_s;
    logic [STATE_W-1:0] pi_s;

    // Round datapath; pi_s holds B[x,y] at lane idx(x,y).
    always_comb begin
        theta_s   = theta(state_in);
        pi_s      = '0;
        state_out = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                pi_s[LANE_W*idx(y, (2*x + 3*y) % 5) +: LANE_W] =
                    rotl(theta_s[LANE_W*idx(x, y) +: LANE_W], RHO[idx(x, y)]);
            end
        end
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                state_out[LANE_W*idx(x, y) +: LANE_W] =
                    pi_s[LANE_W*idx(x, y) +: LANE_W] ^
                    (~pi_s[LANE_W*idx((x + 1) % 5, y) +: LANE_W] &
                      pi_s[LANE_W*idx((x + 2) % 5, y) +: LANE_W]);
            end
        end
        state_out[LANE_W-1:0] = state_out[LANE_W-1:0] ^ rc;
    end

endmodule

// File: rtl/keccak800_perm_ctrl.sv
// Iterative Keccak-f[800] engine: loads a state, applies ROUNDS rounds in groups of
// ROUNDS_PER_CYCLE, then holds the result until the consumer takes it.
module keccak800_perm_ctrl
    import keccak800_pkg::*;
#(
    parameter int ROUNDS           = 22,
    parameter int ROUNDS_PER_CYCLE = 1
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy,
    output logic [4:0]         round_idx
);

    fsm_t               state_r;
    fsm_t               state_next_s;
    logic [STATE_W-1:0] lanes_r;
    logic [4:0]         round_r;
    logic               ready_en_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               load_s;
    logic               step_s;
    logic               last_s;
    logic               in_ready_s;
    logic [STATE_W-1:0] chain_s [0:ROUNDS_PER_CYCLE];

    assign chain_s[0] = lanes_r;

    genvar k;
    for (k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
        keccak800_round u_round (
            .state_in  (chain_s[k]),
            .rc        (rc_at(round_r + 5'(k))),
            .state_out (chain_s[k+1])
        );
    end

    assign last_s = (round_r == 5'(ROUNDS - ROUNDS_PER_CYCLE));

    // Next-state and handshake decode; in_ready never depends on in_valid.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        in_ready_s   = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = ready_en_r;
                if (in_valid && ready_en_r) begin
                    load_s       = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                in_ready_s = ready_en_r & out_ready;
                if (out_valid_r && out_ready) begin
                    if (in_valid) begin
                        load_s       = 1'b1;
                        state_next_s = RUN;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control registers; in_ready stays low until the first edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            ready_en_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            ready_en_r  <= 1'b1;
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s == RUN);
        end
    end

    // State register and round counter; both hold outside load and RUN steps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lanes_r <= '0;
            round_r <= 5'd0;
        end else if (load_s) begin
            lanes_r <= in_state;
            round_r <= 5'd0;
        end else if (step_s) begin
            lanes_r <= chain_s[ROUNDS_PER_CYCLE];
            round_r <= last_s ? 5'd0 : round_r + 5'(ROUNDS_PER_CYCLE);
        end else begin
            lanes_r <= lanes_r;
            round_r <= round_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign round_idx = round_r;
    assign out_state = lanes_r;

endmodule

// File: tb/tb_keccak800_perm_ctrl.sv
// Scoreboard bench for keccak800_perm_ctrl over four configurations sharing one input bus.
module tb_keccak800_perm_ctrl;

    localparam int ND = 4;
    localparam int LAT  [ND] = '{23, 2, 12, 3};
    localparam int NRND [ND] = '{22, 1, 22, 22};

    typedef struct {
        logic [799:0] st;
        int           issue;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [799:0] in_state = '0;
    logic         in_valid_a    [ND];
    logic         out_ready_a   [ND];
    logic         in_ready_a    [ND];
    logic         out_valid_a   [ND];
    logic         busy_a        [ND];
    logic [799:0] out_state_a   [ND];
    logic [4:0]   round_idx_a   [ND];

    exp_t sb [ND][$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [31:0] rc_m [22] = '{
        32'h00000001, 32'h00008082, 32'h0000808A, 32'h80008000, 32'h0000808B,
        32'h80000001, 32'h80008081, 32'h00008009, 32'h0000008A, 32'h00000088,
        32'h80008009, 32'h8000000A, 32'h8000808B, 32'h0000008B, 32'h00008089,
        32'h00008003, 32'h00008002, 32'h00000080, 32'h0000800A, 32'h8000000A,
        32'h80008081, 32'h00008080
    };
    int rho_m [5][5];

    keccak800_perm_ctrl #(.ROUNDS(22), .ROUNDS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .in_state(in_state), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .out_state(out_state_a[0]), .busy(busy_a[0]), .round_idx(round_idx_a[0]));
    keccak800_perm_ctrl #(.ROUNDS(1), .ROUNDS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .in_state(in_state), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .out_state(out_state_a[1]), .busy(busy_a[1]), .round_idx(round_idx_a[1]));
    keccak800_perm_ctrl #(.ROUNDS(22), .ROUNDS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .in_state(in_state), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
        .out_state(out_state_a[2]), .busy(busy_a[2]), .round_idx(round_idx_a[2]));
    keccak800_perm_ctrl #(.ROUNDS(22), .ROUNDS_PER_CYCLE(11)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[3]), .in_ready(in_ready_a[3]),
        .in_state(in_state), .out_valid(out_valid_a[3]), .out_ready(out_ready_a[3]),
        .out_state(out_state_a[3]), .busy(busy_a[3]), .round_idx(round_idx_a[3]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic check_vec(input string name, input logic [799:0] act, input logic [799:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    function automatic logic [31:0] rot32(input logic [31:0] v, input int n);
        if (n == 0) return v;
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference permutation with pi written as a gather: A'[x][y] = A[x+3y][x].
    function automatic logic [799:0] ref_perm(input logic [799:0] s, input int nr);
        logic [31:0] a [5][5];
        logic [31:0] b [5][5];
        logic [31:0] c [5];
        logic [799:0] r;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) a[x][y] = s[32*(x + 5*y) +: 32];
        for (int i = 0; i < nr; i++) begin
            for (int x = 0; x < 5; x++) c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) a[x][y] ^= c[(x + 4) % 5] ^ rot32(c[(x + 1) % 5], 1);
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    b[x][y] = rot32(a[(x + 3*y) % 5][x], rho_m[(x + 3*y) % 5][x]);
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) a[x][y] = b[x][y] ^ (~b[(x + 1) % 5][y] & b[(x + 2) % 5][y]);
            a[0][0] ^= rc_m[i];
        end
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) r[32*(x + 5*y) +: 32] = a[x][y];
        return r;
    endfunction

    function automatic logic [799:0] rand_state();
        logic [799:0] s;
        for (int i = 0; i < 25; i++) s[32*i +: 32] = $urandom();
        return s;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int d, input logic [799:0] st, input logic [799:0] exp);
        int  n;
        bit  done;
        exp_t e;
        n = 0;
        done = 1'b0;
        in_state = st;
        in_valid_a[d] = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready_a[d] === 1'b1) begin
                e.st = exp;
                e.issue = cyc;
                sb[d].push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid_a[d] = 1'b0;
        check_int($sformatf("accept_dut%0d", d), int'(done), 1);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (sb[d].size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_int($sformatf("drain_dut%0d", d), sb[d].size(), 0);
    endtask

    // Monitor: latency on out_valid rise, stability while held, result on handshake.
    initial begin
        logic         prev_ov [ND];
        logic         prev_hs [ND];
        logic [799:0] prev_os [ND];
        exp_t         e;
        for (int d = 0; d < ND; d++) begin
            prev_ov[d] = 1'b0;
            prev_hs[d] = 1'b0;
            prev_os[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (reset) begin
                    prev_ov[d] = 1'b0;
                    prev_hs[d] = 1'b0;
                end else begin
                    if (out_valid_a[d] && !prev_ov[d]) begin
                        if (sb[d].size() == 0) begin
                            n_chk++;
                            $display("FAIL unexpected_output_dut%0d: got out_valid=1, required no output", d);
                        end else begin
                            check_int($sformatf("latency_dut%0d", d), cyc - sb[d][0].issue, LAT[d]);
                        end
                    end
                    if (out_valid_a[d] && prev_ov[d] && !prev_hs[d])
                        check_vec($sformatf("hold_stable_dut%0d", d), out_state_a[d], prev_os[d]);
                    if (out_valid_a[d] && out_ready_a[d] && sb[d].size() != 0) begin
                        e = sb[d].pop_front();
                        check_vec($sformatf("result_dut%0d", d), out_state_a[d], e.st);
                    end
                    prev_ov[d] = out_valid_a[d];
                    prev_hs[d] = out_valid_a[d] & out_ready_a[d];
                    prev_os[d] = out_state_a[d];
                end
            end
        end
    end

    initial begin
        int           x;
        int           y;
        int           nx;
        int           n;
        logic [799:0] s;
        logic [799:0] ones;

        rho_m[0][0] = 0;
        x = 1;
        y = 0;
        for (int t = 0; t < 24; t++) begin
            rho_m[x][y] = ((t + 1) * (t + 2) / 2) % 32;
            nx = y;
            y = (2*x + 3*y) % 5;
            x = nx;
        end
        ones = '1;
        for (int d = 0; d < ND; d++) begin
            in_valid_a[d] = 1'b0;
            out_ready_a[d] = 1'b1;
        end

        // Reset values, then in_ready rising on the first clock after release.
        repeat (2) @(posedge clk);
        #1;
        check_int("rst_out_valid", int'(out_valid_a[0]), 0);
        check_int("rst_busy", int'(busy_a[0]), 0);
        check_int("rst_round_idx", int'(round_idx_a[0]), 0);
        check_int("rst_in_ready", int'(in_ready_a[0]), 0);
        check_vec("rst_out_state", out_state_a[0], '0);
        reset = 1'b0;
        #1;
        check_int("in_ready_before_clk", int'(in_ready_a[0]), 0);
        @(posedge clk);
        #1;
        check_int("in_ready_after_clk", int'(in_ready_a[0]), 1);

        // One round: hand-computed results.
        send(1, '0, {768'd0, 32'h00000001});
        drain(1);
        send(1, ones, {{24{32'hFFFFFFFF}}, 32'hFFFFFFFE});
        drain(1);

        // Full permutation: zero, all-ones, random.
        send(0, '0, ref_perm('0, 22));
        drain(0);
        send(0, ones, ref_perm(ones, 22));
        drain(0);
        for (int i = 0; i < 20; i++) begin
            s = rand_state();
            send(0, s, ref_perm(s, NRND[0]));
            drain(0);
        end

        // Backpressure in DONE, then back-to-back load on release.
        out_ready_a[0] = 1'b0;
        s = rand_state();
        send(0, s, ref_perm(s, 22));
        n = 0;
        while (out_valid_a[0] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("bp_reach_done", int'(out_valid_a[0]), 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_int("bp_in_ready_low", int'(in_ready_a[0]), 0);
            check_int("bp_out_valid_high", int'(out_valid_a[0]), 1);
        end
        @(posedge clk);
        #1;
        out_ready_a[0] = 1'b1;
        s = rand_state();
        send(0, s, ref_perm(s, 22));
        drain(0);

        // in_valid noise while running must not cause an extra acceptance.
        s = rand_state();
        send(0, s, ref_perm(s, 22));
        for (int i = 0; i < 20; i++) begin
            in_valid_a[0] = 1'($urandom_range(0, 1));
            in_state = rand_state();
            @(negedge clk);
            check_int("run_in_ready_low", int'(in_ready_a[0]), 0);
            check_int("run_busy_high", int'(busy_a[0]), 1);
            @(posedge clk);
            #1;
        end
        in_valid_a[0] = 1'b0;
        drain(0);

        // Abort at round 10 with an asynchronous reset.
        s = rand_state();
        send(0, s, ref_perm(s, 22));
        n = 0;
        while (round_idx_a[0] != 5'd10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("abort_round_idx_seen", int'(round_idx_a[0]), 10);
        #1;
        reset = 1'b1;
        #1;
        check_int("abort_out_valid", int'(out_valid_a[0]), 0);
        check_int("abort_busy", int'(busy_a[0]), 0);
        check_int("abort_round_idx", int'(round_idx_a[0]), 0);
        check_int("abort_in_ready", int'(in_ready_a[0]), 0);
        check_vec("abort_out_state", out_state_a[0], '0);
        sb[0].delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        s = rand_state();
        send(0, s, ref_perm(s, 22));
        drain(0);

        // Unrolled configurations.
        for (int d = 2; d < 4; d++) begin
            send(d, '0, ref_perm('0, 22));
            drain(d);
            send(d, ones, ref_perm(ones, 22));
            drain(d);
            for (int i = 0; i < 3; i++) begin
                s = rand_state();
                send(d, s, ref_perm(s, 22));
                drain(d);
            end
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
